// File: rtl/intr_ctrl.sv
// Edge-latched, masked, fixed-priority interrupt controller for the PC controller.
// Holds one request until it is accepted, then follows call/ret depth to spot the ISR return.
module intr_ctrl #(
   parameter int NUM_SRC = 4,
   parameter int DEPTH_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pause,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               save_accum,
   input  logic               call_taken,
   input  logic               ret_taken,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [7:0]         cfg_wdata,
   output logic [7:0]         cfg_rdata,
   output logic               interrupt,
   output logic [2:0]         cause,
   output logic               in_service,
   output logic               error
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

   state_t             r_state, w_state_nxt;
   logic [NUM_SRC-1:0] r_src_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic               r_gie;
   logic [2:0]         r_cause, w_cause_nxt;
   logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
   logic               r_error, w_error_nxt;

   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_accept_clr;
   logic [NUM_SRC-1:0] w_eligible;
   logic               w_accept;

   function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (v[i]) lowest_idx = 3'(i);
   endfunction

   assign w_set      = irq_src & ~r_src_prev;
   assign w_eligible = r_pending & r_mask & {NUM_SRC{r_gie}};
   assign w_accept   = (r_state == S_REQ) && save_accum && !pause;

   always_comb begin
      w_accept_clr = '0;
      for (int i = 0; i < NUM_SRC; i++)
         w_accept_clr[i] = w_accept && (r_cause == 3'(i));
   end

   // Software W1C and the acceptance clear share one mask; a fresh edge still wins.
   assign w_clr = ((cfg_we && (cfg_addr == 2'd1)) ? cfg_wdata[NUM_SRC-1:0] : '0) | w_accept_clr;

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      w_depth_nxt = r_depth;
      w_error_nxt = r_error;
      if (!pause) begin
         case (r_state)
            S_IDLE: begin
               if (w_eligible != '0) begin
                  w_state_nxt = S_REQ;
                  w_cause_nxt = lowest_idx(w_eligible);
               end
            end
            S_REQ: begin
               if (save_accum) begin
                  w_state_nxt = S_SERVICE;
                  w_depth_nxt = '0;
               end
            end
            S_SERVICE: begin
               if (call_taken && !ret_taken) begin
                  if (r_depth == '1) w_error_nxt = 1'b1;
                  else               w_depth_nxt = r_depth + DEPTH_W'(1);
               end else if (ret_taken && !call_taken) begin
                  if (r_depth != '0) w_depth_nxt = r_depth - DEPTH_W'(1);
                  else               w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_src_prev <= '0;
         r_pending  <= '0;
         r_mask     <= '0;
         r_gie      <= 1'b0;
         r_cause    <= '0;
         r_depth    <= '0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cause    <= w_cause_nxt;
         r_depth    <= w_depth_nxt;
         r_error    <= w_error_nxt;
         r_src_prev <= irq_src;
         r_pending  <= (r_pending & ~w_clr) | w_set;
         if (cfg_we && (cfg_addr == 2'd0)) r_mask <= cfg_wdata[NUM_SRC-1:0];
         if (cfg_we && (cfg_addr == 2'd3)) r_gie  <= cfg_wdata[0];
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd0:    cfg_rdata[NUM_SRC-1:0] = r_mask;
         2'd1:    cfg_rdata[NUM_SRC-1:0] = r_pending;
         2'd2:    cfg_rdata[2:0]         = r_cause;
         default: cfg_rdata[0]           = r_gie;
      endcase
   end

   assign interrupt  = (r_state == S_REQ);
   assign in_service = (r_state == S_SERVICE);
   assign cause      = r_cause;
   assign error      = r_error;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus randomized traffic, all compared
// every cycle against a behavioural model of the controller's rules.
module tb_intr_ctrl;

   localparam int NS  = 4;
   localparam int DW  = 4;
   localparam int DMAX = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          pause;
   logic [NS-1:0] irq_src;
   logic          save_accum, call_taken, ret_taken;
   logic          cfg_we;
   logic [1:0]    cfg_addr;
   logic [7:0]    cfg_wdata;
   logic [7:0]    cfg_rdata;
   logic          interrupt;
   logic [2:0]    cause;
   logic          in_service;
   logic          error;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   logic [NS-1:0] m_pend, m_mask, m_prev;
   logic          m_gie, m_err;
   int            m_mode;   // 0 idle, 1 requesting, 2 servicing
   int            m_depth;
   logic [2:0]    m_cause;

   intr_ctrl #(.NUM_SRC(NS), .DEPTH_W(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pause      (pause),
      .irq_src    (irq_src),
      .save_accum (save_accum),
      .call_taken (call_taken),
      .ret_taken  (ret_taken),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .interrupt  (interrupt),
      .cause      (cause),
      .in_service (in_service),
      .error      (error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
   endtask

   function automatic logic [2:0] first_set(input logic [NS-1:0] v);
      for (int i = 0; i < NS; i++)
         if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   function automatic logic [7:0] model_rdata(input logic [1:0] a);
      case (a)
         2'd0:    return {4'b0, m_mask};
         2'd1:    return {4'b0, m_pend};
         2'd2:    return {5'b0, m_cause};
         default: return {7'b0, m_gie};
      endcase
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 1'b0; m_err = 1'b0;
      m_mode = 0; m_depth = 0; m_cause = '0;
   endtask

   // Applies one clock edge's worth of rules using the inputs seen at that edge.
   task automatic model_clk();
      logic [NS-1:0] set_v, clr_v, elig;
      set_v = irq_src & ~m_prev;
      elig  = m_gie ? (m_pend & m_mask) : '0;
      clr_v = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NS-1:0] : '0;
      if (!pause) begin
         if (m_mode == 0) begin
            if (elig != 0) begin
               m_mode  = 1;
               m_cause = first_set(elig);
            end
         end else if (m_mode == 1) begin
            if (save_accum) begin
               clr_v   = clr_v | (NS'(1) << m_cause);
               m_mode  = 2;
               m_depth = 0;
            end
         end else begin
            if (call_taken && !ret_taken) begin
               if (m_depth == DMAX) m_err = 1'b1;
               else m_depth = m_depth + 1;
            end else if (ret_taken && !call_taken) begin
               if (m_depth > 0) m_depth = m_depth - 1;
               else m_mode = 0;
            end
         end
      end
      m_pend = (m_pend & ~clr_v) | set_v;
      m_prev = irq_src;
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[NS-1:0];
      if (cfg_we && cfg_addr == 2'd3) m_gie  = cfg_wdata[0];
   endtask

   task automatic compare_all();
      check("interrupt",  {31'b0, interrupt},  {31'b0, (m_mode == 1)});
      check("in_service", {31'b0, in_service}, {31'b0, (m_mode == 2)});
      check("cause",      {29'b0, cause},      {29'b0, m_cause});
      check("error",      {31'b0, error},      {31'b0, m_err});
      check("cfg_rdata",  {24'b0, cfg_rdata},  {24'b0, model_rdata(cfg_addr)});
   endtask

   task automatic step();
      @(posedge clk);
      model_clk();
      #1;
      compare_all();
      cfg_we = 1'b0; save_accum = 1'b0; call_taken = 1'b0; ret_taken = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
   endtask

   initial begin
      reset_n = 1'b0; pause = 1'b0; irq_src = '0; save_accum = 1'b0;
      call_taken = 1'b0; ret_taken = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0;
      cfg_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_interrupt", {31'b0, interrupt}, 32'd0);
      check("rst_in_service", {31'b0, in_service}, 32'd0);
      check("rst_mask", {24'b0, cfg_rdata}, 32'd0);
      check("rst_error", {31'b0, error}, 32'd0);

      // Single source: pending one edge after the rise, request one edge later
      wr(2'd0, 8'h01);
      wr(2'd3, 8'h01);
      irq_src = 4'b0001; cfg_addr = 2'd1;
      step();
      check("ss_pending", {24'b0, cfg_rdata}, 32'h1);
      check("ss_int_early", {31'b0, interrupt}, 32'd0);
      step();
      check("ss_int", {31'b0, interrupt}, 32'd1);
      check("ss_cause", {29'b0, cause}, 32'd0);
      repeat (3) step();
      check("ss_hold", {31'b0, interrupt}, 32'd1);
      save_accum = 1'b1; step();
      check("ss_in_service", {31'b0, in_service}, 32'd1);
      check("ss_pend_clr", {24'b0, cfg_rdata}, 32'h0);
      ret_taken = 1'b1; step();
      check("ss_return", {31'b0, in_service}, 32'd0);

      // Priority and depth tracking
      irq_src = '0; wr(2'd0, 8'h0F);
      irq_src = 4'b1010; step(); step();
      check("pri_first", {29'b0, cause}, 32'd1);
      save_accum = 1'b1; step();
      call_taken = 1'b1; step();
      call_taken = 1'b1; step();
      ret_taken = 1'b1; step();
      ret_taken = 1'b1; step();
      check("depth_still_isr", {31'b0, in_service}, 32'd1);
      ret_taken = 1'b1; step();
      check("depth_return", {31'b0, in_service}, 32'd0);
      check("gap_idle", {31'b0, interrupt}, 32'd0);
      step();
      check("pri_second_int", {31'b0, interrupt}, 32'd1);
      check("pri_second", {29'b0, cause}, 32'd3);
      save_accum = 1'b1; step();
      for (int k = 0; k < DMAX; k++) begin call_taken = 1'b1; step(); end
      check("ovf_not_yet", {31'b0, error}, 32'd0);
      call_taken = 1'b1; step();
      check("ovf_error", {31'b0, error}, 32'd1);
      for (int k = 0; k < DMAX; k++) begin ret_taken = 1'b1; step(); end
      check("ovf_still_isr", {31'b0, in_service}, 32'd1);
      ret_taken = 1'b1; step();

      // No retraction once requesting
      irq_src = '0; step();
      irq_src = 4'b0001; step(); step();
      check("nr_req", {31'b0, interrupt}, 32'd1);
      wr(2'd3, 8'h00);
      wr(2'd1, 8'h01);
      step();
      check("nr_held", {31'b0, interrupt}, 32'd1);
      save_accum = 1'b1; step();
      ret_taken = 1'b1; step();
      wr(2'd3, 8'h01);

      // Pause while requesting
      irq_src = '0; step();
      irq_src = 4'b0001; step(); step();
      pause = 1'b1; irq_src = 4'b0101; save_accum = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("pause_int", {31'b0, interrupt}, 32'd1);
      end
      pause = 1'b0; cfg_addr = 2'd1; #1;
      check("pause_pending", {24'b0, cfg_rdata}, 32'h5);
      save_accum = 1'b1; step();
      check("pause_accept", {24'b0, cfg_rdata}, 32'h4);

      // Asynchronous reset in the middle of an ISR
      call_taken = 1'b1; step();
      cfg_addr = 2'd0;
      #2 reset_n = 1'b0;
      #1;
      check("arst_interrupt", {31'b0, interrupt}, 32'd0);
      check("arst_in_service", {31'b0, in_service}, 32'd0);
      check("arst_error", {31'b0, error}, 32'd0);
      check("arst_mask", {24'b0, cfg_rdata}, 32'd0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Randomized traffic
      wr(2'd0, 8'h0F);
      wr(2'd3, 8'h01);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) irq_src = NS'($urandom_range(0, 15));
         pause      = ($urandom_range(0, 9) == 0);
         save_accum = ($urandom_range(0, 3) == 0);
         call_taken = ($urandom_range(0, 3) == 0);
         ret_taken  = ($urandom_range(0, 2) == 0);
         cfg_addr   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            cfg_we    = 1'b1;
            cfg_wdata = 8'($urandom);
            if (cfg_addr == 2'd3 && $urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
